// File: rtl/dict_compressor_if.sv
// Handshake bundle for dict_compressor: serial chunk input on one side,
// lookup result with valid/ready on the other.
interface dict_compressor_if #(
    parameter int CHUNK_SIZE = 8,
    parameter int INDEX_BITS = 4
);
    // Valid/ready: a result transfers on a rising edge where out_valid and
    // out_ready are both high. While out_valid is high and out_ready is low,
    // compressed_index, hit and chunk_out hold stable. serial_in is sampled
    // only on edges where shift_enable is high and busy is low.
    logic                  serial_in;
    logic                  shift_enable;
    logic                  out_ready;
    logic [INDEX_BITS-1:0] compressed_index;
    logic                  hit;
    logic [CHUNK_SIZE-1:0] chunk_out;
    logic                  out_valid;
    logic                  busy;

    modport master (
        output serial_in, shift_enable, out_ready,
        input  compressed_index, hit, chunk_out, out_valid, busy
    );

    modport slave (
        input  serial_in, shift_enable, out_ready,
        output compressed_index, hit, chunk_out, out_valid, busy
    );
endinterface

// File: rtl/dict_compressor.sv
// Serial-in dictionary compressor: assembles a chunk MSB first, then scans a
// fixed codebook one entry per cycle and reports the lowest matching index.
module dict_compressor #(
    parameter int CHUNK_SIZE    = 8,
    parameter int CODEBOOK_SIZE = 16,
    parameter int INDEX_BITS    = $clog2(CODEBOOK_SIZE)
) (
    input  logic                clk,
    input  logic                rst_n,
    dict_compressor_if.slave    io_bus,
    output logic [1:0]          o_dbg_state
);
    localparam int CNT_W = $clog2(CHUNK_SIZE);

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_SEARCH  = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [CHUNK_SIZE-1:0] r_shreg;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic [INDEX_BITS-1:0] r_search_idx;
    logic [INDEX_BITS-1:0] r_compressed_index;
    logic                  r_hit;
    logic                  r_out_valid;
    logic                  w_last_bit;
    logic                  w_match;
    logic                  w_last_idx;

    function automatic logic [CHUNK_SIZE-1:0] cb_entry(input logic [INDEX_BITS-1:0] idx);
        logic [7:0] e;
        case (int'(idx))
            0:       e = 8'b00000000;
            1:       e = 8'b00100010;
            2:       e = 8'b10011001;
            3:       e = 8'b10111011;
            4:       e = 8'b11111111;
            5:       e = 8'b10001000;
            6:       e = 8'b11001100;
            7:       e = 8'b01110111;
            8:       e = 8'b00001111;
            9:       e = 8'b11110000;
            10:      e = 8'b01010101;
            11:      e = 8'b10101010;
            12:      e = 8'b00110011;
            13:      e = 8'b11001100;
            14:      e = 8'b11100011;
            15:      e = 8'b00011100;
            default: e = 8'b00000000;
        endcase
        return CHUNK_SIZE'(e);
    endfunction

    assign w_last_bit = (r_bit_cnt == CNT_W'(CHUNK_SIZE - 1));
    assign w_match    = (cb_entry(r_search_idx) == r_shreg);
    assign w_last_idx = (r_search_idx == INDEX_BITS'(CODEBOOK_SIZE - 1));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_COLLECT: if (io_bus.shift_enable && w_last_bit) w_state_next = S_SEARCH;
            S_SEARCH:  if (w_match || w_last_idx) w_state_next = S_DONE;
            S_DONE:    if (io_bus.out_ready) w_state_next = S_COLLECT;
            default:   w_state_next = S_COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_COLLECT;
        else        r_state <= w_state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shreg            <= '0;
            r_bit_cnt          <= '0;
            r_search_idx       <= '0;
            r_compressed_index <= '0;
            r_hit              <= 1'b0;
            r_out_valid        <= 1'b0;
        end else begin
            case (r_state)
                S_COLLECT: begin
                    if (io_bus.shift_enable) begin
                        r_shreg <= {r_shreg[CHUNK_SIZE-2:0], io_bus.serial_in};
                        if (w_last_bit) begin
                            r_bit_cnt    <= '0;
                            r_search_idx <= '0;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                S_SEARCH: begin
                    // Scan ascending so duplicate entries resolve to the lowest index.
                    if (w_match) begin
                        r_compressed_index <= r_search_idx;
                        r_hit              <= 1'b1;
                        r_out_valid        <= 1'b1;
                    end else if (w_last_idx) begin
                        r_compressed_index <= '0;
                        r_hit              <= 1'b0;
                        r_out_valid        <= 1'b1;
                    end else begin
                        r_search_idx <= r_search_idx + 1'b1;
                    end
                end
                S_DONE: begin
                    if (io_bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_bit_cnt   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign io_bus.compressed_index = r_compressed_index;
    assign io_bus.hit              = r_hit;
    assign io_bus.chunk_out        = r_shreg;
    assign io_bus.out_valid        = r_out_valid;
    assign io_bus.busy             = (r_state != S_COLLECT);
    assign o_dbg_state             = r_state;
endmodule

// File: tb/tb_dict_compressor.sv
// Self-checking bench for dict_compressor against a table-lookup reference model.
module tb_dict_compressor;
  logic clk;
  logic rst_n;
  logic [1:0] dbg_state;
  int n_tests;
  int n_fail;

  localparam logic [7:0] REF_CB [16] = '{
    8'b00000000, 8'b00100010, 8'b10011001, 8'b10111011,
    8'b11111111, 8'b10001000, 8'b11001100, 8'b01110111,
    8'b00001111, 8'b11110000, 8'b01010101, 8'b10101010,
    8'b00110011, 8'b11001100, 8'b11100011, 8'b00011100
  };

  dict_compressor_if #(.CHUNK_SIZE(8), .INDEX_BITS(4)) bus ();

  dict_compressor #(.CHUNK_SIZE(8), .CODEBOOK_SIZE(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .io_bus      (bus),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: first matching entry, latency = index+1 or 16 on miss
  function automatic void ref_expect(input logic [7:0] v, output logic h,
                                     output logic [3:0] idx, output int lat);
    h = 1'b0; idx = 4'd0; lat = 16;
    for (int k = 0; k < 16; k++) begin
      if (REF_CB[k] == v) begin
        h = 1'b1; idx = 4'(k); lat = k + 1;
        break;
      end
    end
  endfunction

  // driver: gap_mode 0 = contiguous, 1 = idle cycle after each bit, 2 = random gaps
  task automatic send_chunk(input logic [7:0] v, input int gap_mode);
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk);
      bus.shift_enable = 1'b1;
      bus.serial_in = v[i];
      if (i > 0 && (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 1) == 1))) begin
        @(negedge clk);
        bus.shift_enable = 1'b0;
        bus.serial_in = 1'($urandom_range(0, 1));
      end
    end
    @(posedge clk);
    #1;
    bus.shift_enable = 1'b0;
  endtask

  // counts edges from the last-bit edge until out_valid; -1 on timeout
  task automatic wait_valid(output int lat);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (bus.out_valid !== 1'b1) lat = -1;
  endtask

  task automatic test_reset();
    #1;
    n_tests++;
    if ({bus.out_valid, bus.hit, bus.busy, bus.compressed_index, bus.chunk_out, dbg_state} !== 17'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b hit=%b busy=%b idx=%0d chunk=%h st=%0d, want all 0",
               bus.out_valid, bus.hit, bus.busy, bus.compressed_index, bus.chunk_out, dbg_state);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_tests++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got busy=%b valid=%b, want 0 0", bus.busy, bus.out_valid);
    end
  endtask

  task automatic test_known_vectors();
    logic [7:0] vecs [4];
    logic eh; logic [3:0] ei; int el; int lat;
    vecs[0] = 8'b10011001; vecs[1] = 8'b11001100; vecs[2] = 8'b00000000; vecs[3] = 8'b01000001;
    bus.out_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      ref_expect(vecs[n], eh, ei, el);
      send_chunk(vecs[n], 0);
      n_tests++;
      if (bus.busy !== 1'b1) begin
        n_fail++;
        $display("FAIL known_busy_after_last_bit: chunk=%h got busy=%b want 1", vecs[n], bus.busy);
      end
      wait_valid(lat);
      n_tests++;
      if (lat !== el || bus.compressed_index !== ei || bus.hit !== eh || bus.chunk_out !== vecs[n]) begin
        n_fail++;
        $display("FAIL known_result: chunk=%h got lat=%0d idx=%0d hit=%b out=%h want lat=%0d idx=%0d hit=%b out=%h",
                 vecs[n], lat, bus.compressed_index, bus.hit, bus.chunk_out, el, ei, eh, vecs[n]);
      end
      @(posedge clk);
      #1;
      n_tests++;
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL known_one_cycle_valid: chunk=%h got valid=%b busy=%b want 0 0",
                 vecs[n], bus.out_valid, bus.busy);
      end
    end
  endtask

  task automatic test_hold_stall();
    logic eh; logic [3:0] ei; int el; int lat;
    bus.out_ready = 1'b0;
    ref_expect(8'b01110111, eh, ei, el);
    send_chunk(8'b01110111, 0);
    wait_valid(lat);
    n_tests++;
    if (lat !== el) begin
      n_fail++;
      $display("FAIL stall_latency: got %0d want %0d", lat, el);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      bus.shift_enable = 1'($urandom_range(0, 1));
      bus.serial_in = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      n_tests++;
      if (bus.out_valid !== 1'b1 || bus.busy !== 1'b1 || bus.compressed_index !== ei ||
          bus.hit !== eh || bus.chunk_out !== 8'b01110111) begin
        n_fail++;
        $display("FAIL stall_hold: cycle=%0d got valid=%b busy=%b idx=%0d hit=%b out=%h want 1 1 %0d %b 77",
                 c, bus.out_valid, bus.busy, bus.compressed_index, bus.hit, bus.chunk_out, ei, eh);
      end
    end
    @(negedge clk);
    bus.shift_enable = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_release: got valid=%b busy=%b want 0 0", bus.out_valid, bus.busy);
    end
  endtask

  task automatic test_async_reset();
    logic eh; logic [3:0] ei; int el; int lat;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.shift_enable = 1'b1;
      bus.serial_in = 1'b1;
    end
    @(negedge clk);
    bus.shift_enable = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({bus.out_valid, bus.hit, bus.busy, bus.compressed_index, bus.chunk_out} !== 15'd0) begin
      n_fail++;
      $display("FAIL async_reset_collect: got valid=%b hit=%b busy=%b idx=%0d chunk=%h want all 0",
               bus.out_valid, bus.hit, bus.busy, bus.compressed_index, bus.chunk_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ref_expect(8'b00011100, eh, ei, el);
    send_chunk(8'b00011100, 1);
    wait_valid(lat);
    n_tests++;
    if (lat !== el || bus.compressed_index !== ei || bus.hit !== eh) begin
      n_fail++;
      $display("FAIL async_reset_gapped: got lat=%0d idx=%0d hit=%b want lat=%0d idx=%0d hit=%b",
               lat, bus.compressed_index, bus.hit, el, ei, eh);
    end
    @(posedge clk);
    // second case: reset lands in the middle of a search
    send_chunk(8'b11100011, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.chunk_out !== 8'd0) begin
      n_fail++;
      $display("FAIL async_reset_search: got busy=%b valid=%b chunk=%h want 0 0 00",
               bus.busy, bus.out_valid, bus.chunk_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ref_expect(8'b00100010, eh, ei, el);
    send_chunk(8'b00100010, 0);
    wait_valid(lat);
    n_tests++;
    if (lat !== el || bus.compressed_index !== ei || bus.hit !== eh) begin
      n_fail++;
      $display("FAIL after_search_reset: got lat=%0d idx=%0d hit=%b want lat=%0d idx=%0d hit=%b",
               lat, bus.compressed_index, bus.hit, el, ei, eh);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    logic eh; logic [3:0] ei; int el; int lat;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      ref_expect(REF_CB[k], eh, ei, el);
      send_chunk(REF_CB[k], 0);
      wait_valid(lat);
      n_tests++;
      if (lat !== el || bus.compressed_index !== ei || bus.hit !== 1'b1 || bus.chunk_out !== REF_CB[k]) begin
        n_fail++;
        $display("FAIL b2b_entry: k=%0d got lat=%0d idx=%0d hit=%b out=%h want lat=%0d idx=%0d hit=1 out=%h",
                 k, lat, bus.compressed_index, bus.hit, bus.chunk_out, el, ei, REF_CB[k]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_random();
    logic [7:0] v; logic eh; logic [3:0] ei; int el; int lat; int hold;
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 2) == 0) v = REF_CB[$urandom_range(0, 15)];
      else v = 8'($urandom_range(0, 255));
      hold = $urandom_range(0, 3);
      bus.out_ready = (hold == 0);
      ref_expect(v, eh, ei, el);
      send_chunk(v, 2);
      wait_valid(lat);
      n_tests++;
      if (lat !== el || bus.compressed_index !== ei || bus.hit !== eh || bus.chunk_out !== v) begin
        n_fail++;
        $display("FAIL random_result: chunk=%h got lat=%0d idx=%0d hit=%b out=%h want lat=%0d idx=%0d hit=%b",
                 v, lat, bus.compressed_index, bus.hit, bus.chunk_out, el, ei, eh);
      end
      if (hold > 0) begin
        repeat (hold) @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b1;
      end
      @(posedge clk);
      #1;
      n_tests++;
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL random_accept: chunk=%h hold=%0d got valid=%b busy=%b want 0 0",
                 v, hold, bus.out_valid, bus.busy);
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    rst_n = 1'b0;
    bus.serial_in = 1'b0;
    bus.shift_enable = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    test_reset();
    test_known_vectors();
    test_hold_stall();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
